// File: rtl/rf_param.sv
// Register file with two write / two read ports, a pending-bit scoreboard and a
// sequential clear engine that walks every register once.
//
// state | meaning
// IDLE  | normal operation: writes, reserves, bypassed reads, clear requests accepted
// CLEAR | clr_idx walks 0..NUM_REGS-1 zeroing one register and pending bit per cycle
// DONE  | one-cycle completion pulse; all requests ignored
module rf_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              pend0,
    output logic              pend1,
    input  logic              resv,
    input  logic [ADDR_W-1:0] resv_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_idx;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                idle;
    logic                clearing;
    logic                w0_ok;
    logic                w1_ok;
    logic                resv_ok;

    assign idle     = (state_q == IDLE);
    assign clearing = (state_q == CLEAR);

    // Register 0 is hardwired when ZERO_REG is set, so its writes and reserves vanish here.
    assign w0_ok   = idle && we0  && !((ZERO_REG != 0) && (waddr0 == '0));
    assign w1_ok   = idle && we1  && !((ZERO_REG != 0) && (waddr1 == '0));
    assign resv_ok = idle && resv && !((ZERO_REG != 0) && (resv_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_idx == {ADDR_W{1'b1}}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !clearing) begin
            clr_idx <= '0;
        end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
        end
    end

    // Port 1 is checked first so it wins a same-address write collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs[i] <= '0;
            end else if (clearing && (clr_idx == ADDR_W'(i))) begin
                regs[i] <= '0;
            end else if (w1_ok && (waddr1 == ADDR_W'(i))) begin
                regs[i] <= wdata1;
            end else if (w0_ok && (waddr0 == ADDR_W'(i))) begin
                regs[i] <= wdata0;
            end
        end
    end

    // A reserve outranks a completing write: the new producer still owes a result.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                pending[i] <= 1'b0;
            end else if (clearing && (clr_idx == ADDR_W'(i))) begin
                pending[i] <= 1'b0;
            end else if (resv_ok && (resv_addr == ADDR_W'(i))) begin
                pending[i] <= 1'b1;
            end else if ((w0_ok && (waddr0 == ADDR_W'(i))) ||
                         (w1_ok && (waddr1 == ADDR_W'(i)))) begin
                pending[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata0 = regs[raddr0];
        if (BYPASS != 0) begin
            if (w0_ok && (waddr0 == raddr0)) rdata0 = wdata0;
            if (w1_ok && (waddr1 == raddr0)) rdata0 = wdata1;
        end
        if ((ZERO_REG != 0) && (raddr0 == '0)) rdata0 = '0;
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (BYPASS != 0) begin
            if (w0_ok && (waddr0 == raddr1)) rdata1 = wdata0;
            if (w1_ok && (waddr1 == raddr1)) rdata1 = wdata1;
        end
        if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1 = '0;
    end

    assign pend0 = pending[raddr0];
    assign pend1 = pending[raddr1];

endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param: a default instance and a ZERO_REG=1 instance share stimulus
// and are checked every cycle against an array-based model plus literal expectations.
module tb_rf_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1, resv, clr_req;
    logic [2:0]  waddr0, waddr1, raddr0, raddr1, resv_addr;
    logic [15:0] wdata0, wdata1;

    logic [15:0] rd0 [2];
    logic [15:0] rd1 [2];
    logic        pd0 [2];
    logic        pd1 [2];
    logic        busy [2];
    logic        done [2];

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [15:0] mem    [2][8];
    bit          pend_m [2][8];
    int          clr_pos = -1;
    bit          done_m  = 1'b0;

    always #5 clk = ~clk;

    rf_param u_def (
        .clk(clk), .rst(rst), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0[0]), .rdata1(rd1[0]),
        .pend0(pd0[0]), .pend1(pd1[0]), .resv(resv), .resv_addr(resv_addr),
        .clr_req(clr_req), .clr_busy(busy[0]), .clr_done(done[0])
    );

    rf_param #(.ZERO_REG(1)) u_zero (
        .clk(clk), .rst(rst), .we0(we0), .we1(we1),
        .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0[1]), .rdata1(rd1[1]),
        .pend0(pd0[1]), .pend1(pd1[1]), .resv(resv), .resv_addr(resv_addr),
        .clr_req(clr_req), .clr_busy(busy[1]), .clr_done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit wr_ok(int z, bit en, logic [2:0] a);
        return en && !(z == 1 && a == 3'd0);
    endfunction

    function automatic logic [15:0] exp_rd(int z, logic [2:0] ra);
        logic [15:0] v;
        if (z == 1 && ra == 3'd0) return 16'h0;
        v = mem[z][ra];
        if (clr_pos < 0 && !done_m) begin
            if (wr_ok(z, we0, waddr0) && waddr0 == ra) v = wdata0;
            if (wr_ok(z, we1, waddr1) && waddr1 == ra) v = wdata1;
        end
        return v;
    endfunction

    // Model: plain array semantics of the register file and clear sequence.
    always @(posedge clk) begin
        if (rst) begin
            for (int z = 0; z < 2; z++)
                for (int a = 0; a < 8; a++) begin
                    mem[z][a] = 16'h0;
                    pend_m[z][a] = 1'b0;
                end
            clr_pos = -1;
            done_m = 1'b0;
        end else if (done_m) begin
            done_m = 1'b0;
        end else if (clr_pos >= 0) begin
            for (int z = 0; z < 2; z++) begin
                mem[z][clr_pos] = 16'h0;
                pend_m[z][clr_pos] = 1'b0;
            end
            clr_pos++;
            if (clr_pos == 8) begin
                clr_pos = -1;
                done_m = 1'b1;
            end
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (wr_ok(z, we0, waddr0)) begin
                    mem[z][waddr0] = wdata0;
                    pend_m[z][waddr0] = 1'b0;
                end
                if (wr_ok(z, we1, waddr1)) begin
                    mem[z][waddr1] = wdata1;
                    pend_m[z][waddr1] = 1'b0;
                end
                if (wr_ok(z, resv, resv_addr)) pend_m[z][resv_addr] = 1'b1;
            end
            if (clr_req) clr_pos = 0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int z = 0; z < 2; z++) begin
                chk($sformatf("cyc_rdata0[%0d]", z), 32'(rd0[z]), 32'(exp_rd(z, raddr0)));
                chk($sformatf("cyc_rdata1[%0d]", z), 32'(rd1[z]), 32'(exp_rd(z, raddr1)));
                chk($sformatf("cyc_pend0[%0d]", z), 32'(pd0[z]), 32'(pend_m[z][raddr0]));
                chk($sformatf("cyc_pend1[%0d]", z), 32'(pd1[z]), 32'(pend_m[z][raddr1]));
                chk($sformatf("cyc_busy[%0d]", z), 32'(busy[z]), 32'(clr_pos >= 0));
                chk($sformatf("cyc_done[%0d]", z), 32'(done[z]), 32'(done_m));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we0 = 0; we1 = 0; resv = 0; clr_req = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; resv_addr = 0;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            we0 = 1; waddr0 = 3'(i); wdata0 = 16'h1000 + 16'(i) + 16'h1;
            resv = (i % 2 == 1); resv_addr = 3'(i ^ 1);
            tick();
        end
        idle_in();
        tick();
    endtask

    int busy_cnt, done_cnt;

    initial begin
        idle_in();
        raddr0 = 0; raddr1 = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        check_en = 1'b1;
        chk("reset_rdata0", 32'(rd0[0]), 32'h0);
        chk("reset_busy", 32'(busy[0]), 32'h0);

        // Same-cycle bypass, then stored value
        we0 = 1; waddr0 = 3; wdata0 = 16'hA5A5; raddr0 = 3;
        #1 chk("bypass_a5a5", 32'(rd0[0]), 32'hA5A5);
        tick();
        idle_in();
        #1 chk("stored_a5a5", 32'(rd0[0]), 32'hA5A5);

        // Dual write collision: port 1 wins
        we0 = 1; we1 = 1; waddr0 = 5; waddr1 = 5; wdata0 = 16'h1111; wdata1 = 16'h2222;
        tick();
        idle_in(); raddr1 = 5;
        #1 chk("collide_2222", 32'(rd1[0]), 32'h2222);

        // Bypass priority port 1 over port 0
        we0 = 1; we1 = 1; waddr0 = 6; waddr1 = 6; wdata0 = 16'h0606; wdata1 = 16'h6666; raddr0 = 6;
        #1 chk("bypass_prio", 32'(rd0[0]), 32'h6666);
        tick();
        idle_in();

        // Scoreboard
        resv = 1; resv_addr = 2; raddr0 = 2;
        #1 chk("pend_no_bypass", 32'(pd0[0]), 32'h0);
        tick();
        idle_in();
        #1 chk("pend_set", 32'(pd0[0]), 32'h1);
        resv = 1; resv_addr = 2; we0 = 1; waddr0 = 2; wdata0 = 16'h0022;
        tick();
        idle_in();
        #1 chk("pend_new_producer", 32'(pd0[0]), 32'h1);
        we0 = 1; waddr0 = 2; wdata0 = 16'h0023;
        tick();
        idle_in();
        #1 chk("pend_cleared", 32'(pd0[0]), 32'h0);

        // Mixed traffic on both ports
        for (int k = 0; k < 16; k++) begin
            we0 = k[0]; waddr0 = 3'(k * 3); wdata0 = 16'(16'h0100 * k + 7);
            we1 = k[1]; waddr1 = 3'(k + 1); wdata1 = 16'(16'hF000 ^ k);
            resv = k[2]; resv_addr = 3'(k * 5);
            raddr0 = 3'(k * 3); raddr1 = 3'(k + 2);
            tick();
        end
        idle_in();

        // Full clear, with writes/resv/clr_req held through CLEAR and DONE
        fill();
        clr_req = 1;
        tick();
        busy_cnt = 0; done_cnt = 0;
        if (busy[0]) busy_cnt++;
        we0 = 1; waddr0 = 7; wdata0 = 16'hBEEF; resv = 1; resv_addr = 4;
        for (int k = 0; k < 9; k++) begin
            raddr0 = 3'(k); raddr1 = 3'(7 - k);
            tick();
            if (busy[0]) busy_cnt++;
            if (done[0]) done_cnt++;
        end
        chk("clr_idle_after_done", 32'(busy[0] | done[0]), 32'h0);
        idle_in();
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("clr_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            raddr0 = 3'(i);
            #1 chk("cleared_rdata", 32'(rd0[0]), 32'h0);
            chk("cleared_pend", 32'(pd0[0]), 32'h0);
        end
        tick();

        // Reset mid-CLEAR with index 4 in progress
        fill();
        clr_req = 1;
        tick();
        idle_in();
        tick(); tick(); tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        chk("abort_busy", 32'(busy[0]), 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            raddr0 = 3'(i); raddr1 = 3'(i + 4);
            #1 chk("abort_rdata", 32'(rd0[0]), 32'h0);
            if (done[0]) done_cnt++;
            tick();
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Hardwired register 0
        we0 = 1; waddr0 = 0; wdata0 = 16'hFFFF; resv = 1; resv_addr = 0; raddr0 = 0;
        #1 chk("zero_bypass", 32'(rd0[1]), 32'h0);
        chk("nonzero_bypass", 32'(rd0[0]), 32'hFFFF);
        tick();
        idle_in();
        #1 chk("zero_rdata", 32'(rd0[1]), 32'h0);
        chk("zero_pend", 32'(pd0[1]), 32'h0);
        chk("nonzero_pend", 32'(pd0[0]), 32'h1);
        tick();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
